// File: rtl/uart_tx_frame_pkg.sv
// Shared definitions for the UART frame logic: FSM state encoding, parity
// mode constants and the parity helper. Also intended for the receive side.
package uart_tx_frame_pkg;

  // Widest payload the frame logic supports
  localparam int MAX_DATA_W = 9;

  // Parity modes selected by the PARITY parameter
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Parity bit for a zero-extended payload; zero padding leaves the XOR unchanged
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] d, input int mode);
    logic p;
    case (mode)
      PARITY_EVEN: p = ^d;
      PARITY_ODD:  p = ~^d;
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time divider: emits a one-cycle tick on the last clock of every bit.
// Held at zero while restart is high so the first bit of a frame starts aligned.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count clocks within a bit, wrapping to zero at the bit end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = ~restart & (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART serialiser: one-entry holding register in front of a shift register,
// frame sequencer (start, data LSB first, optional parity, stop bits) and a
// registered tx pin. A queued byte starts right after the previous stop bit.
module uart_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              rdy_4_data,
  output logic              transmitting,
  output logic              tx
);

  import uart_tx_frame_pkg::*;

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [BIT_W-1:0]  w_bit_cnt_next;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] w_hold_next;
  logic              r_hold_full;
  logic              w_hold_full_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic              r_par;
  logic              w_par_next;
  logic              r_tx;
  logic              w_tx_next;
  logic              r_transmitting;
  logic              w_transmitting_next;
  logic              w_tick;
  logic              w_restart;
  logic              w_accept;
  logic              w_load;
  logic [MAX_DATA_W-1:0] w_par_data;

  // Bit-time counter only runs while a frame is on the line
  assign w_restart = (r_state == ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(w_restart),
    .tick   (w_tick)
  );

  // Next-state logic; every bit-level transition waits for the bit-end tick
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) w_state_next = ST_START;
        else             w_state_next = ST_IDLE;
      end
      ST_START: begin
        if (w_tick) w_state_next = ST_DATA;
        else        w_state_next = ST_START;
      end
      ST_DATA: begin
        if (w_tick && (r_bit_cnt == DATA_LAST)) begin
          if (PARITY != PARITY_NONE) w_state_next = ST_PARITY;
          else                       w_state_next = ST_STOP;
        end else begin
          w_state_next = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_tick) w_state_next = ST_STOP;
        else        w_state_next = ST_PARITY;
      end
      ST_STOP: begin
        if (w_tick && (r_bit_cnt == STOP_LAST)) begin
          if (r_hold_full) w_state_next = ST_START;
          else             w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_STOP;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath next values: holding/shift registers, parity, bit counter, tx level
  always_comb begin
    w_accept   = data_valid & ~r_hold_full;
    // A frame start always moves the holding entry into the shift register
    w_load     = (w_state_next == ST_START) && (r_state != ST_START);
    w_par_data = '0;
    w_par_data[DATA_W-1:0] = r_hold;

    // Load consumes the old entry before an accept can refill the slot
    if (w_accept) w_hold_next = data_in;
    else          w_hold_next = r_hold;
    w_hold_full_next = w_accept | (r_hold_full & ~w_load);

    if (w_load) begin
      w_shift_next = r_hold;
      w_par_next   = calc_parity(w_par_data, PARITY);
    end else if ((r_state == ST_DATA) && (w_state_next == ST_DATA) && w_tick) begin
      w_shift_next = r_shift >> 1;
      w_par_next   = r_par;
    end else begin
      w_shift_next = r_shift;
      w_par_next   = r_par;
    end

    if (w_state_next != r_state) begin
      w_bit_cnt_next = '0;
    end else if (w_tick && (r_state != ST_IDLE)) begin
      w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
    end else begin
      w_bit_cnt_next = r_bit_cnt;
    end

    // Line level for the bit that the next state will present
    case (w_state_next)
      ST_IDLE:   w_tx_next = 1'b1;
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
      ST_PARITY: w_tx_next = w_par_next;
      ST_STOP:   w_tx_next = 1'b1;
      default:   w_tx_next = 1'b1;
    endcase

    w_transmitting_next = (w_state_next != ST_IDLE);
  end

  // State register; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and output registers; reset discards the holding entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt      <= '0;
      r_hold         <= '0;
      r_hold_full    <= 1'b0;
      r_shift        <= '0;
      r_par          <= 1'b0;
      r_tx           <= 1'b1;
      r_transmitting <= 1'b0;
    end else begin
      r_bit_cnt      <= w_bit_cnt_next;
      r_hold         <= w_hold_next;
      r_hold_full    <= w_hold_full_next;
      r_shift        <= w_shift_next;
      r_par          <= w_par_next;
      r_tx           <= w_tx_next;
      r_transmitting <= w_transmitting_next;
    end
  end

  assign rdy_4_data   = ~r_hold_full;
  assign transmitting = r_transmitting;
  assign tx           = r_tx;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances cover the default frame,
// even and odd parity, and a wide-bit/2-stop/7-bit configuration.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic rst;

  // default instance
  logic [7:0] d_data;
  logic       d_valid, d_rdy, d_txing, d_tx;
  // even parity instance
  logic [7:0] e_data;
  logic       e_valid, e_rdy, e_txing, e_tx;
  // odd parity instance
  logic [7:0] o_data;
  logic       o_valid, o_rdy, o_txing, o_tx;
  // 7 data bits, 4 clocks per bit, 2 stop bits
  logic [6:0] w_data;
  logic       w_valid, w_rdy, w_txing, w_tx;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  uart_tx_frame u_d (
    .clk(clk), .rst(rst), .data_in(d_data), .data_valid(d_valid),
    .rdy_4_data(d_rdy), .transmitting(d_txing), .tx(d_tx)
  );

  uart_tx_frame #(.PARITY(1)) u_e (
    .clk(clk), .rst(rst), .data_in(e_data), .data_valid(e_valid),
    .rdy_4_data(e_rdy), .transmitting(e_txing), .tx(e_tx)
  );

  uart_tx_frame #(.PARITY(2)) u_o (
    .clk(clk), .rst(rst), .data_in(o_data), .data_valid(o_valid),
    .rdy_4_data(o_rdy), .transmitting(o_txing), .tx(o_tx)
  );

  uart_tx_frame #(.DATA_W(7), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_w (
    .clk(clk), .rst(rst), .data_in(w_data), .data_valid(w_valid),
    .rdy_4_data(w_rdy), .transmitting(w_txing), .tx(w_tx)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy_of(input int sel);
    case (sel)
      0: return d_rdy;
      1: return e_rdy;
      2: return o_rdy;
      default: return w_rdy;
    endcase
  endfunction

  function automatic logic tx_of(input int sel);
    case (sel)
      0: return d_tx;
      1: return e_tx;
      2: return o_tx;
      default: return w_tx;
    endcase
  endfunction

  function automatic logic txing_of(input int sel);
    case (sel)
      0: return d_txing;
      1: return e_txing;
      2: return o_txing;
      default: return w_txing;
    endcase
  endfunction

  // Wait (bounded) for ready, offer one byte for one edge; returns at the
  // falling edge just after the accepting rising edge.
  task automatic send(input int sel, input logic [8:0] b);
    for (int k = 0; k < 200 && !rdy_of(sel); k++) @(negedge clk);
    check_val("send_rdy", {63'd0, rdy_of(sel)}, 64'd1);
    case (sel)
      0: begin d_data = b[7:0]; d_valid = 1'b1; end
      1: begin e_data = b[7:0]; e_valid = 1'b1; end
      2: begin o_data = b[7:0]; o_valid = 1'b1; end
      default: begin w_data = b[6:0]; w_valid = 1'b1; end
    endcase
    @(negedge clk);
    d_valid = 1'b0; e_valid = 1'b0; o_valid = 1'b0; w_valid = 1'b0;
  endtask

  // Sample n falling edges, sample 0 taken at call time
  task automatic capture(input int sel, input int n, output logic [63:0] txv,
                         output logic [63:0] rdyv, output int hi_cnt,
                         output int first_hi, output int last_hi);
    txv = '0; rdyv = '0; hi_cnt = 0; first_hi = -1; last_hi = -1;
    for (int i = 0; i < n; i++) begin
      txv[i]  = tx_of(sel);
      rdyv[i] = rdy_of(sel);
      if (txing_of(sel)) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
        last_hi = i;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] txv, rdyv;
    logic [39:0] exp40;
    logic [9:0]  wframe;
    int hi, fh, lh;

    rst = 1'b1;
    d_valid = 1'b0; e_valid = 1'b0; o_valid = 1'b0; w_valid = 1'b0;
    d_data = 8'h00; e_data = 8'h00; o_data = 8'h00; w_data = 7'h00;
    repeat (3) @(negedge clk);

    // reset state of every instance
    for (int s = 0; s < 4; s++) begin
      check_val("rst_tx",    {63'd0, tx_of(s)},    64'd1);
      check_val("rst_rdy",   {63'd0, rdy_of(s)},   64'd1);
      check_val("rst_txing", {63'd0, txing_of(s)}, 64'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: default frame of 0x88
    send(0, 9'h088);
    capture(0, 14, txv, rdyv, hi, fh, lh);
    check_val("t1_idle_before", {63'd0, txv[0]}, 64'd1);
    check_val("t1_frame", {54'd0, txv[10:1]}, {54'd0, 10'b1100010000});
    check_val("t1_idle_after", {61'd0, txv[13:11]}, {61'd0, 3'b111});
    check_val("t1_txing_cnt", hi, 64'd10);
    check_val("t1_txing_first", fh, 64'd1);
    check_val("t1_rdy_full", {63'd0, rdyv[0]}, 64'd0);
    check_val("t1_rdy_back", {63'd0, rdyv[1]}, 64'd1);

    // 2: even parity 0x44, odd parity 0x11
    send(1, 9'h044);
    capture(1, 14, txv, rdyv, hi, fh, lh);
    check_val("t2_even_frame", {53'd0, txv[11:1]}, {53'd0, 11'b10010001000});
    check_val("t2_even_cnt", hi, 64'd11);
    check_val("t2_even_idle", {62'd0, txv[13:12]}, {62'd0, 2'b11});
    send(2, 9'h011);
    capture(2, 14, txv, rdyv, hi, fh, lh);
    check_val("t2_odd_frame", {53'd0, txv[11:1]}, {53'd0, 11'b11000100010});
    check_val("t2_odd_cnt", hi, 64'd11);

    // 3: back-to-back 0x22 then 0x11
    fork
      begin send(0, 9'h022); send(0, 9'h011); end
      begin capture(0, 30, txv, rdyv, hi, fh, lh); end
    join
    check_val("t3_frames", {44'd0, txv[21:2]}, {44'd0, 20'b1000100010_1001000100});
    check_val("t3_idle", {56'd0, txv[29:22]}, {56'd0, 8'hFF});
    check_val("t3_txing_cnt", hi, 64'd20);
    check_val("t3_txing_first", fh, 64'd2);
    check_val("t3_txing_last", lh, 64'd21);
    repeat (2) @(negedge clk);

    // 4: 7 data bits, 4 clocks per bit, 2 stop bits, 0x55
    send(3, 9'h055);
    capture(3, 44, txv, rdyv, hi, fh, lh);
    wframe = 10'b1110101010;
    for (int i = 0; i < 40; i++) exp40[i] = wframe[i / 4];
    check_val("t4_frame", {24'd0, txv[40:1]}, {24'd0, exp40});
    check_val("t4_txing_cnt", hi, 64'd40);
    check_val("t4_txing_first", fh, 64'd1);
    check_val("t4_idle_after", {61'd0, txv[43:41]}, {61'd0, 3'b111});

    // 5: data_valid while holding full is ignored
    fork
      begin
        send(0, 9'h022);
        send(0, 9'h011);
        check_val("t5_rdy_full", {63'd0, d_rdy}, 64'd0);
        d_data = 8'hFF; d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0; d_data = 8'h00;
      end
      begin capture(0, 40, txv, rdyv, hi, fh, lh); end
    join
    check_val("t5_frames", {44'd0, txv[21:2]}, {44'd0, 20'b1000100010_1001000100});
    check_val("t5_no_extra", {46'd0, txv[39:22]}, {46'd0, 18'h3FFFF});
    check_val("t5_txing_cnt", hi, 64'd20);
    check_val("t5_rdy_end", {63'd0, d_rdy}, 64'd1);

    // 6: reset during data bit 3 with a byte queued
    send(0, 9'h088);
    send(0, 9'h0FF);
    repeat (3) @(negedge clk);
    check_val("t6_mid_txing", {63'd0, d_txing}, 64'd1);
    check_val("t6_mid_bit3", {63'd0, d_tx}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("t6_rst_tx", {63'd0, d_tx}, 64'd1);
    check_val("t6_rst_txing", {63'd0, d_txing}, 64'd0);
    check_val("t6_rst_rdy", {63'd0, d_rdy}, 64'd1);
    rst = 1'b0;
    capture(0, 6, txv, rdyv, hi, fh, lh);
    check_val("t6_discarded_cnt", hi, 64'd0);
    check_val("t6_discarded_tx", {58'd0, txv[5:0]}, {58'd0, 6'h3F});
    send(0, 9'h011);
    capture(0, 14, txv, rdyv, hi, fh, lh);
    check_val("t6_after_frame", {54'd0, txv[10:1]}, {54'd0, 10'b1000100010});
    check_val("t6_after_cnt", hi, 64'd10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
